// File: rtl/cpu_pkg.sv
// Shared definitions for the branch/status datapath: branch kinds,
// condition codes, FSM state encodings and default widths.
package cpu_pkg;

    localparam int PC_W_DEFAULT   = 9;
    localparam int DATA_W_DEFAULT = 16;

    typedef enum logic [1:0] {
        BR_B   = 2'b00,
        BR_BL  = 2'b01,
        BR_BX  = 2'b10,
        BR_BLX = 2'b11
    } br_kind_t;

    typedef enum logic [2:0] {
        COND_AL  = 3'b000,
        COND_EQ  = 3'b001,
        COND_NE  = 3'b010,
        COND_LT  = 3'b011,
        COND_LE  = 3'b100,
        COND_NV5 = 3'b101,
        COND_NV6 = 3'b110,
        COND_NV7 = 3'b111
    } cond_t;

    // FSM encodings kept as plain constants so older code can match on them
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_EVAL   = 2'd1;
    localparam logic [1:0] ST_UPDATE = 2'd2;

    // BL and BLX are the kinds that produce a return address
    function automatic logic kind_links(input logic [1:0] kind);
        return kind[0];
    endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch-condition evaluator. Status is {Z,N,V}; register
// branches ignore the condition field and always redirect.
module cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] status,
    input  logic [2:0] cond,
    input  logic [1:0] kind,
    output logic       taken
);

    logic z_flag;
    logic n_flag;
    logic v_flag;

    assign z_flag = status[2];
    assign n_flag = status[1];
    assign v_flag = status[0];

    // Decide whether the branch redirects the PC
    always_comb begin
        taken = 1'b0;
        if (kind == BR_BX || kind == BR_BLX) begin
            taken = 1'b1;
        end else begin
            case (cond)
                COND_AL: taken = 1'b1;
                COND_EQ: taken = z_flag;
                COND_NE: taken = ~z_flag;
                COND_LT: taken = n_flag ^ v_flag;
                COND_LE: taken = (n_flag ^ v_flag) | z_flag;
                default: taken = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/status_branch_unit.sv
// Status register plus a three-state branch resolver (IDLE/EVAL/UPDATE).
// A request is captured in IDLE, its outcome computed from the status
// register during EVAL, and the PC is written as UPDATE ends.
module status_branch_unit
    import cpu_pkg::*;
#(
    parameter int PC_W   = PC_W_DEFAULT,
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [2:0]        znv_in,
    input  logic              load_s,
    input  logic              pc_inc,
    input  logic              br_valid,
    output logic              br_ready,
    input  logic [1:0]        br_kind,
    input  logic [2:0]        br_cond,
    input  logic [DATA_W-1:0] sximm8,
    input  logic [DATA_W-1:0] reg_target,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        status,
    output logic              done,
    output logic              taken,
    output logic              link_valid,
    output logic [DATA_W-1:0] link_data
);

    logic [1:0]        state;
    logic [1:0]        kind_q;
    logic [2:0]        cond_q;
    logic [PC_W-1:0]   imm_q;
    logic [PC_W-1:0]   reg_tgt_q;
    logic              taken_q;
    logic              link_q;
    logic [PC_W-1:0]   target_q;
    logic [DATA_W-1:0] link_data_q;

    logic              accept;
    logic              eval_taken;
    logic [PC_W-1:0]   pc_plus1;
    logic [PC_W-1:0]   rel_target;
    logic [PC_W-1:0]   eval_target;
    logic              unused_high_bits;

    // Only the low PC_W bits of offsets and register targets ever reach the PC
    assign unused_high_bits = ^{sximm8[DATA_W-1:PC_W], reg_target[DATA_W-1:PC_W]};

    assign br_ready    = (state == ST_IDLE) && !reset;
    assign accept      = br_valid && br_ready;
    assign pc_plus1    = pc + PC_W'(1);
    assign rel_target  = pc_plus1 + imm_q;
    assign eval_target = kind_q[1] ? reg_tgt_q : rel_target;

    assign done        = (state == ST_UPDATE) && !reset;
    assign taken       = done && taken_q;
    assign link_valid  = done && link_q;
    assign link_data   = link_data_q;

    cond_eval u_cond_eval (
        .status (status),
        .cond   (cond_q),
        .kind   (kind_q),
        .taken  (eval_taken)
    );

    // Status flags load whenever asked, regardless of branch activity
    always_ff @(posedge clk) begin
        if (reset) begin
            status <= 3'b000;
        end else if (load_s) begin
            status <= znv_in;
        end
    end

    // Sequencer and program counter: capture, evaluate, then commit the PC
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            pc    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state <= ST_EVAL;
                    end else if (pc_inc) begin
                        pc <= pc_plus1;
                    end
                end
                ST_EVAL: begin
                    state <= ST_UPDATE;
                end
                ST_UPDATE: begin
                    pc    <= target_q;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Request capture on handshake and outcome registration at the end of EVAL
    always_ff @(posedge clk) begin
        if (reset) begin
            kind_q      <= '0;
            cond_q      <= '0;
            imm_q       <= '0;
            reg_tgt_q   <= '0;
            taken_q     <= 1'b0;
            link_q      <= 1'b0;
            target_q    <= '0;
            link_data_q <= '0;
        end else if (accept) begin
            kind_q    <= br_kind;
            cond_q    <= br_cond;
            imm_q     <= sximm8[PC_W-1:0];
            reg_tgt_q <= reg_target[PC_W-1:0];
        end else if (state == ST_EVAL) begin
            taken_q  <= eval_taken;
            link_q   <= eval_taken && kind_links(kind_q);
            target_q <= eval_taken ? eval_target : pc_plus1;
            if (eval_taken && kind_links(kind_q)) begin
                link_data_q <= DATA_W'(pc_plus1);
            end
        end
    end

endmodule

// File: doc/status_branch_unit.md
STATUS_BRANCH_UNIT -- requirements
Module: status_branch_unit

Interface
REQ-001 Parameter: PC_W, default 9, program-counter width.
REQ-002 Parameter: DATA_W, default 16, datapath width of immediate, register target and link data.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  reset is synchronous and active-high.
REQ-005 znv_in  input  3  ALU flags {Z,N,V}, bit2=Z, bit1=N, bit0=V.
REQ-006 load_s  input  1  latch znv_in into status register.
REQ-007 pc_inc  input  1  sequential PC increment request.
REQ-008 br_valid  input  1  branch request valid.
REQ-009 br_ready  output  1  unit can accept a branch request.
REQ-010 br_kind  input  2  00 B (PC-relative), 01 BL, 10 BX, 11 BLX.
REQ-011 br_cond  input  3  condition code for B kind.
REQ-012 sximm8  input  DATA_W  sign-extended branch offset.
REQ-013 reg_target  input  DATA_W  register-supplied target for BX/BLX.
REQ-014 pc  output  PC_W  current program counter.
REQ-015 status  output  3  registered {Z,N,V}.
REQ-016 done  output  1  one-cycle pulse, branch resolved.
REQ-017 taken  output  1  valid with done; 1 = PC redirected.
REQ-018 link_valid  output  1  one-cycle pulse with done for BL/BLX.
REQ-019 link_data  output  DATA_W  return address, valid with link_valid.

Function
REQ-020 Status register SHALL load znv_in on any cycle with load_s=1, independent of FSM state.
REQ-021 FSM SHALL have states IDLE, EVAL, UPDATE; br_ready=1 only in IDLE.
REQ-022 Handshake: br_valid & br_ready SHALL capture br_kind, br_cond, sximm8, reg_target and move IDLE->EVAL; br_valid outside IDLE is ignored.
REQ-023 EVAL SHALL compute taken and target from the status register value present during EVAL, then go to UPDATE.
REQ-024 UPDATE SHALL write pc, pulse done (and link_valid if applicable), return to IDLE; done is 2 cycles after acceptance edge.
REQ-025 Conditions for B/BL: 000 always; 001 Z; 010 !Z; 011 N!=V; 100 (N!=V)|Z; 101-111 never taken.
REQ-026 BX and BLX SHALL ignore br_cond and be always taken.
REQ-027 Taken B/BL target SHALL be (pc+1+sximm8) truncated to PC_W bits (modular wrap).
REQ-028 Taken BX/BLX target SHALL be reg_target[PC_W-1:0].
REQ-029 Not-taken SHALL set pc to pc+1 modulo 2^PC_W.
REQ-030 BL/BLX SHALL assert link_valid only when taken, with link_data = zero-extended (pc+1) of the branch instruction.
REQ-031 pc_inc SHALL increment pc (511->0 wrap) only in IDLE with no handshake that cycle; handshake has priority, pc_inc elsewhere ignored.
REQ-032 load_s in the acceptance cycle SHALL be visible to EVAL; load_s during EVAL SHALL NOT affect that branch.
REQ-033 done, taken, link_valid SHALL be 0 outside the UPDATE cycle.

Reset
REQ-034 Reset SHALL set pc=0, status=000, state IDLE, done=taken=link_valid=0, link_data=0.
REQ-035 br_ready SHALL be 0 while reset is asserted and 1 the first cycle after.
REQ-036 Reset mid-operation SHALL abort the branch with no done pulse and no pc write; reset overrides load_s and pc_inc.

Structure
REQ-037 Shared package cpu_pkg SHALL hold br_kind and condition-code enums, FSM state enum, PC_W default.
REQ-038 Condition evaluation SHALL be a combinational sub-module cond_eval (status, cond, kind -> taken).

Verification
REQ-039 Reset then pc_inc x3 -> pc=3, status=000, br_ready=1.
REQ-040 load_s with znv_in=100, BEQ cond 001, sximm8=0x0005 at pc=3 -> done 2 cycles later, taken=1, pc=9.
REQ-041 status N=1,V=0, BLE cond 100, sximm8=0xFFFE at pc=10 -> taken=1, pc=9; status 000, BNE with Z=1 -> taken=0, pc=pc+1.
REQ-042 BLX reg_target=0x0123 at pc=20 -> pc=0x123, link_valid=1, link_data=0x0015.
REQ-043 pc=510, B always sximm8=0x0003 -> pc=2 (wrap); pc=511 with pc_inc -> pc=0.
REQ-044 reset asserted in EVAL -> no done, pc=0; br_valid during EVAL/UPDATE and pc_inc during EVAL -> ignored.
